// File: rtl/softmax_exp_ctrl.sv
// -----------------------------------------------------------------------------
// softmax_exp_ctrl
//   Runs one softmax row through the shared exp unit. The first pass reads the
//   row buffer and finds max(x). The second pass re-reads the row and sends
//   clamp(x - max) to the exp unit. Each e^x result is written back to the
//   same row-buffer index and added into a saturating sum, which the
//   downstream normaliser uses.
//
//   Ports
//     clk, arst         clock; asynchronous active-high reset
//     start, vec_len    row request (sampled only in IDLE), row length 0..2^ADDR_W
//     busy, done        row in progress; one-cycle completion pulse
//     sum_out           saturating sum of the written exp results
//     rd_en/rd_addr     row-buffer read port; rd_data returns one cycle later
//     exp_en/exp_x      exp-unit enable and operand (x - max, always <= 0)
//     exp_y             exp-unit result, valid EXP_LAT cycles after exp_x is sampled
//     wr_en/wr_addr     row-buffer write-back of exp results
//     wr_data
// -----------------------------------------------------------------------------
module softmax_exp_ctrl #(
  parameter int DWIDTH   = 16,
  parameter int FRAC_BIT = 11,
  parameter int INT_BIT  = 5,
  parameter int ADDR_W   = 6,
  parameter int EXP_LAT  = 2,
  parameter int SUM_W    = 22
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     start,
  input  logic [ADDR_W:0]          vec_len,
  output logic                     busy,
  output logic                     done,
  output logic [SUM_W-1:0]         sum_out,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DWIDTH-1:0] rd_data,
  output logic                     exp_en,
  output logic signed [DWIDTH-1:0] exp_x,
  input  logic [DWIDTH-1:0]        exp_y,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DWIDTH-1:0]        wr_data
);

  localparam int CLAMP_SH = INT_BIT - 1 + FRAC_BIT;
  // Lowest exp-unit input (-2^(INT_BIT-1) in Q.FRAC_BIT), at DWIDTH+1 bits.
  localparam logic signed [DWIDTH:0] CLAMP_MIN =
    {{(DWIDTH + 1 - CLAMP_SH){1'b1}}, {CLAMP_SH{1'b0}}};
  localparam logic signed [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam int ACC_W = ((SUM_W > DWIDTH) ? SUM_W : DWIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    EXP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;

  logic [ADDR_W-1:0]        last_idx;
  logic signed [DWIDTH-1:0] max_val;
  logic                     scan_vld_p0;
  logic                     vld_p0;
  logic [ADDR_W-1:0]        idx_p0;
  logic                     vld_p1;
  logic [ADDR_W-1:0]        idx_p1;
  logic                     vld_p2 [EXP_LAT];
  logic [ADDR_W-1:0]        idx_p2 [EXP_LAT];
  logic                     exp_en_nxt;

  // x - max at full precision; anything below the exp-unit range is pinned to
  // its floor. The difference is never positive, so no upper clamp is needed.
  function automatic logic signed [DWIDTH-1:0] clamp_diff(
    input logic signed [DWIDTH-1:0] x,
    input logic signed [DWIDTH-1:0] m
  );
    logic signed [DWIDTH:0] d;
    d = $signed({x[DWIDTH-1], x}) - $signed({m[DWIDTH-1], m});
    if (d < CLAMP_MIN) d = CLAMP_MIN;
    return d[DWIDTH-1:0];
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(
    input logic [SUM_W-1:0]  acc,
    input logic [DWIDTH-1:0] y
  );
    logic [ACC_W-1:0] s;
    s = ACC_W'(acc) + ACC_W'(y);
    if (s > ACC_W'({SUM_W{1'b1}})) return {SUM_W{1'b1}};
    return s[SUM_W-1:0];
  endfunction

  // exp_en is registered one cycle ahead: it must be high whenever an operand
  // sits on exp_x or a result is still inside the exp unit.
  always_comb begin
    exp_en_nxt = vld_p0 | vld_p1;
    for (int k = 0; k < EXP_LAT - 1; k++) exp_en_nxt = exp_en_nxt | vld_p2[k];
  end

  assign wr_en   = vld_p2[EXP_LAT-1];
  assign wr_addr = idx_p2[EXP_LAT-1];
  assign wr_data = wr_en ? exp_y : '0;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum_out     <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      exp_en      <= 1'b0;
      exp_x       <= '0;
      last_idx    <= '0;
      max_val     <= '0;
      scan_vld_p0 <= 1'b0;
      vld_p0      <= 1'b0;
      idx_p0      <= '0;
      vld_p1      <= 1'b0;
      idx_p1      <= '0;
      for (int k = 0; k < EXP_LAT; k++) begin
        vld_p2[k] <= 1'b0;
        idx_p2[k] <= '0;
      end
    end else begin
      // ---- p0: read data returns from the row buffer ----
      scan_vld_p0 <= rd_en && (state == SCAN);
      vld_p0      <= rd_en && (state == EXP);
      idx_p0      <= rd_addr;

      // ---- p1: clamped difference presented to the exp unit ----
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        exp_x  <= clamp_diff(rd_data, max_val);
        idx_p1 <= idx_p0;
      end

      // ---- p2: tag pipe tracking results inside the exp unit ----
      vld_p2[0] <= vld_p1;
      idx_p2[0] <= idx_p1;
      for (int k = 1; k < EXP_LAT; k++) begin
        vld_p2[k] <= vld_p2[k-1];
        idx_p2[k] <= idx_p2[k-1];
      end

      exp_en <= exp_en_nxt;
      if (vld_p2[EXP_LAT-1]) sum_out <= sat_add(sum_out, exp_y);

      case (state)
        IDLE: begin
          if (start) begin
            sum_out  <= '0;
            last_idx <= vec_len[ADDR_W-1:0] - ADDR_W'(1);
            if (vec_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= SCAN;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= '0;
              max_val <= MOST_NEG;
            end
          end
        end
        SCAN: begin
          if (scan_vld_p0 && (rd_data > max_val)) max_val <= rd_data;
          if (rd_en) begin
            if (rd_addr == last_idx) rd_en <= 1'b0;
            else                     rd_addr <= rd_addr + ADDR_W'(1);
          end else if (scan_vld_p0) begin
            // Reads are gap-free, so data valid with no read pending is the
            // final element; max is settled after this edge.
            state   <= EXP;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        EXP: begin
          if (rd_addr == last_idx) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (vld_p2[EXP_LAT-1] && (idx_p2[EXP_LAT-1] == last_idx)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_exp_ctrl.sv
module tb_softmax_exp_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 6;
  localparam int L   = 2;
  localparam int SW  = 22;
  localparam int SWS = 12;

  logic                 clk = 1'b0;
  logic                 arst;
  logic                 start;
  logic [AW:0]          vec_len;
  logic                 busy, done;
  logic [SW-1:0]        sum_out;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic                 exp_en;
  logic signed [DW-1:0] exp_x;
  logic [DW-1:0]        exp_y;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;

  logic                 s_busy, s_done, s_rd_en, s_exp_en, s_wr_en;
  logic [SWS-1:0]       s_sum;
  logic [AW-1:0]        s_rd_addr, s_wr_addr;
  logic signed [DW-1:0] s_exp_x;
  logic [DW-1:0]        s_wr_data;

  always #5 clk = ~clk;

  softmax_exp_ctrl #(.DWIDTH(DW), .FRAC_BIT(11), .INT_BIT(5), .ADDR_W(AW),
                     .EXP_LAT(L), .SUM_W(SW)) dut (
    .clk(clk), .arst(arst), .start(start), .vec_len(vec_len),
    .busy(busy), .done(done), .sum_out(sum_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .exp_en(exp_en), .exp_x(exp_x), .exp_y(exp_y),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Narrow-accumulator copy fed with the same row and exp results.
  softmax_exp_ctrl #(.DWIDTH(DW), .FRAC_BIT(11), .INT_BIT(5), .ADDR_W(AW),
                     .EXP_LAT(L), .SUM_W(SWS)) dut_s (
    .clk(clk), .arst(arst), .start(start), .vec_len(vec_len),
    .busy(s_busy), .done(s_done), .sum_out(s_sum),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(rd_data),
    .exp_en(s_exp_en), .exp_x(s_exp_x), .exp_y(exp_y),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data)
  );

  // Ideal exp: round(2048 * e^(x/2048)).
  function automatic int exp_model(input int x);
    real r;
    r = $exp(real'(x) / 2048.0) * 2048.0;
    return int'(r);
  endfunction

  // Row buffer (read side) and exp-unit models.
  logic signed [DW-1:0] mem [64];
  logic [DW-1:0]        ep [L];
  logic signed [DW-1:0] xp [L];

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(posedge clk) begin
    if (exp_en) begin
      ep[0] <= DW'(exp_model(int'(exp_x)));
      xp[0] <= exp_x;
      for (int k = 1; k < L; k++) begin
        ep[k] <= ep[k-1];
        xp[k] <= xp[k-1];
      end
    end
  end
  assign exp_y = ep[L-1];

  typedef struct {
    int addr;
    int x;
    int y;
  } wr_t;

  wr_t wr_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  rd_cnt, ex_cnt, wr_cnt;
  int  exp_sum;
  int  row_x [64];

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rd_en)  rd_cnt++;
    if (exp_en) ex_cnt++;
    if (wr_en) begin
      wr_cnt++;
      n_tests++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got write addr=%0d data=%0d, required no write", wr_addr, wr_data);
      end else begin
        e = wr_q.pop_front();
        if (wr_addr !== AW'(e.addr) || int'(xp[L-1]) !== e.x || wr_data !== DW'(e.y)) begin
          n_fail++;
          $display("FAIL wr_entry: got addr=%0d exp_x=%0d data=%0d, required addr=%0d exp_x=%0d data=%0d",
                   wr_addr, int'(xp[L-1]), wr_data, e.addr, e.x, e.y);
        end
      end
    end
  end

  task automatic start_row(input int n);
    int mx, d;
    mx = -32768;
    exp_sum = 0;
    for (int i = 0; i < n; i++) begin
      mem[i] = DW'(row_x[i]);
      if (row_x[i] > mx) mx = row_x[i];
    end
    for (int i = 0; i < n; i++) begin
      d = row_x[i] - mx;
      if (d < -32768) d = -32768;
      wr_q.push_back('{i, d, exp_model(d)});
      exp_sum += exp_model(d);
    end
    rd_cnt = 0;
    ex_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    vec_len = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the accepted start until done; lat = -1 on timeout.
  task automatic wait_done(input int limit, input int pulse_at,
                           output int lat, output int busy_cyc, output logic busy_at_done);
    lat = -1;
    busy_cyc = 0;
    busy_at_done = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == pulse_at) vec_len = (AW+1)'(5);
      if (done) begin
        lat = c;
        busy_at_done = busy;
        break;
      end
      if (busy) busy_cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    start = 1'b0;
    vec_len = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, rd_en, exp_en, wr_en} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 00000", {busy, done, rd_en, exp_en, wr_en});
    end
    n_tests++;
    if (sum_out !== '0 || exp_x !== '0 || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got sum=%0d exp_x=%0d rd_addr=%0d wr_addr=%0d wr_data=%0d, required all 0",
               sum_out, exp_x, rd_addr, wr_addr, wr_data);
    end
    arst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_row(input string name, input int exp_lat, input int n, input int lat,
                           input int busy_cyc, input logic busy_at_done);
    n_tests++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
    n_tests++;
    if (busy_cyc !== exp_lat - 1 || busy_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: got %0d busy cycles (busy@done=%b), required %0d (0)",
               name, busy_cyc, busy_at_done, exp_lat - 1);
    end
    n_tests++;
    if (sum_out !== SW'(exp_sum)) begin
      n_fail++;
      $display("FAIL %s_sum: got %0d, required %0d", name, sum_out, exp_sum);
    end
    n_tests++;
    if (wr_q.size() !== 0 || wr_cnt !== n || rd_cnt !== 2 * n || ex_cnt !== n + L) begin
      n_fail++;
      $display("FAIL %s_counts: got pending=%0d wr=%0d rd=%0d exp_en=%0d, required 0 %0d %0d %0d",
               name, wr_q.size(), wr_cnt, rd_cnt, ex_cnt, n, 2 * n, n + L);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    logic bd;
    row_x[0] = -2048; row_x[1] = -4096; row_x[2] = -6144; row_x[3] = 2048;
    start_row(4);
    wait_done(200, 0, lat, bc, bd);
    check_row("basic", 2 * 4 + L + 4, 4, lat, bc, bd);
    n_tests++;
    if (sum_out !== SW'(2465)) begin
      n_fail++;
      $display("FAIL basic_sum_const: got %0d, required 2465", sum_out);
    end
  endtask

  task automatic test_clamp();
    int lat, bc;
    logic bd;
    row_x[0] = 7 * 2048; row_x[1] = -15 * 2048;
    start_row(2);
    wait_done(200, 0, lat, bc, bd);
    check_row("clamp", 2 * 2 + L + 4, 2, lat, bc, bd);
  endtask

  task automatic test_zero_len();
    int lat, bc;
    logic bd;
    start_row(0);
    wait_done(50, 0, lat, bc, bd);
    n_tests++;
    if (lat !== 1 || bc !== 0 || bd !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_timing: got lat=%0d busy=%0d, required lat=1 busy=0", lat, bc);
    end
    n_tests++;
    if (sum_out !== '0 || rd_cnt !== 0 || ex_cnt !== 0 || wr_cnt !== 0) begin
      n_fail++;
      $display("FAIL zero_len_activity: got sum=%0d rd=%0d exp_en=%0d wr=%0d, required all 0",
               sum_out, rd_cnt, ex_cnt, wr_cnt);
    end
  endtask

  task automatic test_full_row();
    int lat, bc;
    logic bd;
    for (int i = 0; i < 64; i++) row_x[i] = 0;
    start_row(64);
    wait_done(400, 40, lat, bc, bd);
    check_row("full_row", 2 * 64 + L + 4, 64, lat, bc, bd);
    n_tests++;
    if (sum_out !== SW'(131072)) begin
      n_fail++;
      $display("FAIL full_row_sum_const: got %0d, required 131072", sum_out);
    end
    rd_cnt = 0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || rd_cnt !== 0) begin
      n_fail++;
      $display("FAIL ignored_start: got busy=%b reads=%0d after row, required 0 0", busy, rd_cnt);
    end
  endtask

  task automatic test_saturation();
    int lat, bc;
    logic bd;
    for (int i = 0; i < 4; i++) row_x[i] = 0;
    start_row(4);
    wait_done(200, 0, lat, bc, bd);
    check_row("sat", 2 * 4 + L + 4, 4, lat, bc, bd);
    n_tests++;
    if (s_sum !== SWS'(4095) || s_done !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_narrow_sum: got %0d (done=%b), required 4095 (1)", s_sum, s_done);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    logic bd;
    for (int i = 0; i < 8; i++) row_x[i] = (i * 1500) - 4000;
    start_row(8);
    repeat (13) @(negedge clk);
    n_tests++;
    if (exp_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_active: got exp_en=%b busy=%b, required 1 1", exp_en, busy);
    end
    #2 arst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, rd_en, exp_en, wr_en} !== 5'b0 || exp_x !== '0 || sum_out !== '0 ||
        rd_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got ctrl=%b exp_x=%0d sum=%0d rd_addr=%0d wr_data=%0d, required all 0",
               {busy, done, rd_en, exp_en, wr_en}, exp_x, sum_out, rd_addr, wr_data);
    end
    @(negedge clk);
    arst = 1'b0;
    wr_q.delete();
    @(negedge clk);
    row_x[0] = 1024; row_x[1] = -512; row_x[2] = 3000; row_x[3] = -7000; row_x[4] = 2999;
    start_row(5);
    wait_done(200, 0, lat, bc, bd);
    check_row("post_reset", 2 * 5 + L + 4, 5, lat, bc, bd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_zero_len();
    test_full_row();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
